// File: rtl/sopc_cpu_debug_cmd_sync_if.sv
// Bundle between the TCK-side update logic / OCI consumer and the sysclk debug command receiver.
// The receiver takes the slave view; the driving side (shift logic plus consumer) takes the master view.
interface sopc_cpu_debug_cmd_sync_if #(
    parameter int IR_W  = 2,
    parameter int DW    = 38,
    parameter int DEPTH = 4
);
    localparam int NCMD = 2 ** IR_W;
    localparam int LW   = $clog2(DEPTH) + 1;

    logic              udr_tgl;
    logic [IR_W-1:0]   ir_in;
    logic [DW-1:0]     sr;
    logic              cmd_ready;
    logic              clear_ovf;

    logic              cmd_valid;
    logic [IR_W-1:0]   cmd_ir;
    logic [DW-1:0]     jdo;
    logic [NCMD-1:0]   take_action;
    logic [NCMD-1:0]   take_no_action;
    logic [LW-1:0]     fifo_level;
    logic              overflow;

    modport slave (
        input  udr_tgl, ir_in, sr, cmd_ready, clear_ovf,
        output cmd_valid, cmd_ir, jdo, take_action, take_no_action, fifo_level, overflow
    );

    modport master (
        output udr_tgl, ir_in, sr, cmd_ready, clear_ovf,
        input  cmd_valid, cmd_ir, jdo, take_action, take_no_action, fifo_level, overflow
    );
endinterface

// File: rtl/sopc_cpu_debug_cmd_sync.sv
// Sysclk debug command receiver: syncs UDR toggles, queues {ir, sr}, pops into one-hot take_* pulses.
// Toggle-to-valid SYNC_STAGES+1 edges, pulse one edge after pop; full FIFO drops new commands and sets overflow.
module sopc_cpu_debug_cmd_sync #(
    parameter int IR_W        = 2,
    parameter int DW          = 38,
    parameter int ACT_BIT     = 37,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AUTO_ACK    = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    sopc_cpu_debug_cmd_sync_if.slave  bus
);
    localparam int NCMD = 2 ** IR_W;
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_push;

    logic [IR_W-1:0]        r_mem_ir [DEPTH];
    logic [DW-1:0]          r_mem_sr [DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [LW-1:0]          r_level;
    logic [LW-1:0]          w_level_nxt;
    logic                   r_valid;

    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_drop;
    logic [IR_W-1:0]        w_head_ir;
    logic [DW-1:0]          w_head_sr;
    logic [NCMD-1:0]        w_dec;

    logic [DW-1:0]          r_jdo;
    logic [NCMD-1:0]        r_take_act;
    logic [NCMD-1:0]        r_take_nact;
    logic                   r_overflow;

    // Only the last stage is compared against its delayed copy; earlier stages absorb metastability.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.udr_tgl};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_push = r_sync[SYNC_STAGES-1] ^ r_prev;

    assign w_full = (r_level == LW'(DEPTH));
    assign w_pop  = r_valid & (bus.cmd_ready | (AUTO_ACK != 0));
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    assign w_head_ir = r_mem_ir[r_rptr];
    assign w_head_sr = r_mem_sr[r_rptr];

    always_comb begin
        w_dec            = '0;
        w_dec[w_head_ir] = 1'b1;
    end

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage carries no reset; validity is tracked solely by the level counter.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_ir[r_wptr] <= bus.ir_in;
            r_mem_sr[r_wptr] <= bus.sr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jdo       <= '0;
            r_take_act  <= '0;
            r_take_nact <= '0;
        end else if (w_pop) begin
            r_jdo       <= w_head_sr;
            r_take_act  <= w_head_sr[ACT_BIT] ? w_dec : '0;
            r_take_nact <= w_head_sr[ACT_BIT] ? '0 : w_dec;
        end else begin
            r_take_act  <= '0;
            r_take_nact <= '0;
        end
    end

    // A fresh drop outranks a coincident clear so no loss goes unreported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.cmd_valid      = r_valid;
    assign bus.cmd_ir         = w_head_ir;
    assign bus.jdo            = r_jdo;
    assign bus.take_action    = r_take_act;
    assign bus.take_no_action = r_take_nact;
    assign bus.fifo_level     = r_level;
    assign bus.overflow       = r_overflow;

    a_level_bound: assert property (@(posedge clk) disable iff (!reset_n) r_level <= LW'(DEPTH));
    a_one_pulse:   assert property (@(posedge clk) disable iff (!reset_n)
                                    $onehot0({r_take_act, r_take_nact}));
endmodule

// File: tb/tb_sopc_cpu_debug_cmd_sync.sv
// Directed bench: one receiver in auto-acknowledge mode, one in valid/ready mode, shared clock and reset.
module tb_sopc_cpu_debug_cmd_sync;
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    localparam logic [37:0] S1 = 38'h2012345678;
    localparam logic [37:0] S2 = 38'h0ABCDEF012;

    sopc_cpu_debug_cmd_sync_if #(.IR_W(2), .DW(38), .DEPTH(4)) if_a ();
    sopc_cpu_debug_cmd_sync_if #(.IR_W(2), .DW(38), .DEPTH(4)) if_h ();

    sopc_cpu_debug_cmd_sync #(
        .IR_W(2), .DW(38), .ACT_BIT(37), .DEPTH(4), .SYNC_STAGES(2), .AUTO_ACK(1)
    ) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    sopc_cpu_debug_cmd_sync #(
        .IR_W(2), .DW(38), .ACT_BIT(37), .DEPTH(4), .SYNC_STAGES(2), .AUTO_ACK(0)
    ) u_dut_h (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_sr(input int i);
        logic [36:0] lo;
        lo = 37'(i * 4660 + 5);
        return {i[0], lo};
    endfunction

    // Expected one-hot pulse for entry i: bit = i mod 4; action vector when i is odd.
    function automatic logic [3:0] pulse(input int i, input bit want_act);
        logic [3:0] v;
        v = 4'b0001 << (i % 4);
        return (i[0] == want_act) ? v : 4'b0000;
    endfunction

    task automatic send_a(input logic [1:0] ir, input logic [37:0] s);
        if_a.ir_in   = ir;
        if_a.sr      = s;
        if_a.udr_tgl = ~if_a.udr_tgl;
    endtask

    task automatic send_h(input int i);
        if_h.ir_in   = 2'(i);
        if_h.sr      = mk_sr(i);
        if_h.udr_tgl = ~if_h.udr_tgl;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        if_a.udr_tgl = 1'b0; if_a.ir_in = '0; if_a.sr = '0; if_a.cmd_ready = 1'b0; if_a.clear_ovf = 1'b0;
        if_h.udr_tgl = 1'b0; if_h.ir_in = '0; if_h.sr = '0; if_h.cmd_ready = 1'b0; if_h.clear_ovf = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);

        chk("rst_a_valid", 64'(if_a.cmd_valid), 64'(0));
        chk("rst_a_level", 64'(if_a.fifo_level), 64'(0));
        chk("rst_a_ovf",   64'(if_a.overflow), 64'(0));
        chk("rst_a_jdo",   64'(if_a.jdo), 64'(0));
        chk("rst_a_act",   64'(if_a.take_action), 64'(0));
        chk("rst_a_nact",  64'(if_a.take_no_action), 64'(0));
        chk("rst_h_valid", 64'(if_h.cmd_valid), 64'(0));
        chk("rst_h_level", 64'(if_h.fifo_level), 64'(0));

        // Single action command through the auto-acknowledge receiver.
        send_a(2'b01, S1);
        tick(3);
        chk("t1_valid", 64'(if_a.cmd_valid), 64'(1));
        chk("t1_level", 64'(if_a.fifo_level), 64'(1));
        chk("t1_cmd_ir", 64'(if_a.cmd_ir), 64'(1));
        chk("t1_act_early", 64'(if_a.take_action), 64'(0));
        tick(1);
        chk("t1_act", 64'(if_a.take_action), 64'(4'b0010));
        chk("t1_nact", 64'(if_a.take_no_action), 64'(0));
        chk("t1_jdo", 64'(if_a.jdo), 64'(S1));
        chk("t1_valid_after", 64'(if_a.cmd_valid), 64'(0));
        tick(1);
        chk("t1_act_gone", 64'(if_a.take_action), 64'(0));
        chk("t1_jdo_hold", 64'(if_a.jdo), 64'(S1));

        // No-action command on the top code.
        send_a(2'b11, S2);
        tick(4);
        chk("t2_nact", 64'(if_a.take_no_action), 64'(4'b1000));
        chk("t2_act", 64'(if_a.take_action), 64'(0));
        chk("t2_jdo", 64'(if_a.jdo), 64'(S2));
        tick(1);
        chk("t2_nact_gone", 64'(if_a.take_no_action), 64'(0));

        // Fill the handshake receiver past capacity, then drain in order.
        for (int i = 0; i < 5; i++) begin
            send_h(i);
            tick(4);
        end
        chk("t3_level", 64'(if_h.fifo_level), 64'(4));
        chk("t3_ovf", 64'(if_h.overflow), 64'(1));
        chk("t3_valid", 64'(if_h.cmd_valid), 64'(1));
        chk("t3_head_ir", 64'(if_h.cmd_ir), 64'(0));
        if_h.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk($sformatf("t3_act_%0d", i), 64'(if_h.take_action), 64'(pulse(i, 1'b1)));
            chk($sformatf("t3_nact_%0d", i), 64'(if_h.take_no_action), 64'(pulse(i, 1'b0)));
            chk($sformatf("t3_jdo_%0d", i), 64'(if_h.jdo), 64'(mk_sr(i)));
        end
        chk("t3_level_empty", 64'(if_h.fifo_level), 64'(0));
        chk("t3_valid_empty", 64'(if_h.cmd_valid), 64'(0));
        if_h.cmd_ready = 1'b0;
        tick(1);
        chk("t3_quiet_act", 64'(if_h.take_action), 64'(0));
        chk("t3_quiet_nact", 64'(if_h.take_no_action), 64'(0));

        if_h.clear_ovf = 1'b1;
        tick(1);
        if_h.clear_ovf = 1'b0;
        chk("t5_clear", 64'(if_h.overflow), 64'(0));

        // Full FIFO with push and pop on the same edge.
        for (int i = 10; i < 14; i++) begin
            send_h(i);
            tick(4);
        end
        chk("t4_level_full", 64'(if_h.fifo_level), 64'(4));
        chk("t4_ovf_pre", 64'(if_h.overflow), 64'(0));
        send_h(14);
        tick(2);
        if_h.cmd_ready = 1'b1;
        tick(1);
        if_h.cmd_ready = 1'b0;
        chk("t4_level", 64'(if_h.fifo_level), 64'(4));
        chk("t4_ovf", 64'(if_h.overflow), 64'(0));
        chk("t4_jdo", 64'(if_h.jdo), 64'(mk_sr(10)));
        chk("t4_nact", 64'(if_h.take_no_action), 64'(pulse(10, 1'b0)));
        chk("t4_act", 64'(if_h.take_action), 64'(pulse(10, 1'b1)));
        chk("t4_head_ir", 64'(if_h.cmd_ir), 64'(3));

        // Clear coincident with a drop: the drop must win.
        send_h(15);
        tick(2);
        if_h.clear_ovf = 1'b1;
        tick(1);
        if_h.clear_ovf = 1'b0;
        chk("t5_set_wins", 64'(if_h.overflow), 64'(1));
        chk("t5_level", 64'(if_h.fifo_level), 64'(4));
        chk("t5_head_ir", 64'(if_h.cmd_ir), 64'(3));
        tick(1);
        chk("t5_sticky", 64'(if_h.overflow), 64'(1));

        // Reset while three entries are queued.
        if_h.cmd_ready = 1'b1;
        tick(1);
        if_h.cmd_ready = 1'b0;
        chk("t6_pop_act", 64'(if_h.take_action), 64'(pulse(11, 1'b1)));
        chk("t6_level3", 64'(if_h.fifo_level), 64'(3));
        reset_n = 1'b0;
        if_h.udr_tgl = 1'b0;
        if_a.udr_tgl = 1'b0;
        #1;
        chk("t6_rst_level", 64'(if_h.fifo_level), 64'(0));
        chk("t6_rst_valid", 64'(if_h.cmd_valid), 64'(0));
        chk("t6_rst_act", 64'(if_h.take_action), 64'(0));
        chk("t6_rst_ovf", 64'(if_h.overflow), 64'(0));
        if_h.cmd_ready = 1'b1;
        tick(2);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk($sformatf("t6_post_act_%0d", k), 64'(if_h.take_action), 64'(0));
            chk($sformatf("t6_post_nact_%0d", k), 64'(if_h.take_no_action), 64'(0));
        end
        chk("t6_post_valid", 64'(if_h.cmd_valid), 64'(0));

        // Receiver still usable after the reset.
        send_h(20);
        tick(4);
        chk("t6_new_nact", 64'(if_h.take_no_action), 64'(pulse(20, 1'b0)));
        chk("t6_new_jdo", 64'(if_h.jdo), 64'(mk_sr(20)));
        if_h.cmd_ready = 1'b0;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
